// File: rtl/tape_display_reader.sv
// Tape display reader: walks the VGA raster, fetches one tape byte per
// 8x8 cell and turns it into an RGB444 pixel with an optional cursor outline.
module tape_display_reader #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int CELL_SHIFT = 3,
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [9:0]            x,
  input  logic [9:0]            y,
  input  logic                  in_display_area,
  input  logic                  frame_start,
  input  logic [ADDR_WIDTH-1:0] view_base,
  input  logic [ADDR_WIDTH-1:0] cursor_addr,
  input  logic                  cursor_en,
  output logic [ADDR_WIDTH-1:0] vga_data_addr,
  input  logic [7:0]            vga_cell,
  output logic                  pix_valid,
  output logic [11:0]           pix_rgb
);

  localparam int COLS = H_ACTIVE >> CELL_SHIFT;

  logic                  synced;
  logic                  cur_en_q;
  logic [ADDR_WIDTH-1:0] cursor_q;
  logic [ADDR_WIDTH-1:0] line_base;
  logic [ADDR_WIDTH-1:0] addr;
  logic [CELL_SHIFT-1:0] px;
  logic [CELL_SHIFT-1:0] py;
  logic                  active;
  logic                  on_edge;
  logic                  hit;
  logic                  row_end;
  logic [1:0]            vis_q;
  logic [1:0]            edge_q;
  logic [1:0]            hit_q;
  logic [11:0]           rgb_next;

  assign px = x[CELL_SHIFT-1:0];
  assign py = y[CELL_SHIFT-1:0];

  // Out-of-range coordinates are illegal input; masking them is free.
  assign active = in_display_area
                  && (x < 10'(H_ACTIVE))
                  && (y < 10'(V_ACTIVE));

  assign addr    = line_base + ADDR_WIDTH'(x >> CELL_SHIFT);
  assign on_edge = (px == '0) || (px == '1)
                   || (py == '0) || (py == '1);
  assign hit     = cur_en_q && (addr == cursor_q);
  assign row_end = active && (x == 10'(H_ACTIVE - 1)) && (py == '1);

  always_comb begin
    rgb_next = '0;
    if (!vis_q[1])
      rgb_next = '0;
    else if (hit_q[1] && edge_q[1])
      rgb_next = 12'hF00;
    else if (vga_cell == '0)
      rgb_next = '0;
    else
      rgb_next = {vga_cell[7:5], vga_cell[7],
                  vga_cell[4:2], vga_cell[4],
                  vga_cell[1:0], vga_cell[1:0]};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      synced        <= 1'b0;
      cur_en_q      <= 1'b0;
      cursor_q      <= '0;
      line_base     <= '0;
      vga_data_addr <= '0;
      vis_q         <= '0;
      edge_q        <= '0;
      hit_q         <= '0;
      pix_valid     <= 1'b0;
      pix_rgb       <= '0;
    end else begin
      // Display parameters are latched once per frame to avoid tearing.
      if (frame_start) begin
        line_base <= view_base;
        cursor_q  <= cursor_addr;
        cur_en_q  <= cursor_en;
        synced    <= 1'b1;
      end else if (row_end) begin
        line_base <= line_base + ADDR_WIDTH'(COLS);
      end

      if (synced && active)
        vga_data_addr <= addr;

      vis_q     <= {vis_q[0], synced && active};
      edge_q    <= {edge_q[0], on_edge};
      hit_q     <= {hit_q[0], hit};
      pix_valid <= vis_q[1];
      pix_rgb   <= rgb_next;
    end
  end

endmodule

// File: tb/tb_tape_display_reader.sv
// Randomized bench for tape_display_reader against a per-pixel model
// computed from frame base, cell row/column and the colour rules.
module tb_tape_display_reader;

  logic        clk = 1'b0;
  logic        resetn;
  logic [9:0]  x, y;
  logic        in_display_area, frame_start;
  logic [14:0] view_base, cursor_addr;
  logic        cursor_en;
  logic [14:0] vga_data_addr;
  logic [7:0]  vga_cell;
  logic        pix_valid;
  logic [11:0] pix_rgb;

  logic [7:0]  tape [0:32767];

  int n_vec = 0;
  int n_err = 0;

  logic        m_synced;
  logic        m_cen;
  logic [14:0] m_base, m_cur, m_addr;
  logic [12:0] q[$];

  always #5 clk = ~clk;

  always_ff @(posedge clk) vga_cell <= tape[vga_data_addr];

  tape_display_reader dut (
    .clk(clk), .resetn(resetn), .x(x), .y(y),
    .in_display_area(in_display_area), .frame_start(frame_start),
    .view_base(view_base), .cursor_addr(cursor_addr),
    .cursor_en(cursor_en), .vga_data_addr(vga_data_addr),
    .vga_cell(vga_cell), .pix_valid(pix_valid), .pix_rgb(pix_rgb)
  );

  function automatic logic [11:0] colour(bit h, bit e, logic [7:0] c);
    if (h && e) return 12'hF00;
    if (c == 8'd0) return 12'h000;
    return {c[7:5], c[7], c[4:2], c[4], c[1:0], c[1:0]};
  endfunction

  task automatic fill_tape();
    for (int i = 0; i < 32768; i++)
      tape[i] = ($urandom_range(3) == 0) ? 8'd0 : 8'($urandom);
  endtask

  task automatic step(input int sx, input int sy, input bit ide,
                      input bit fs);
    logic [14:0] a;
    bit vis, h, ed;
    logic [12:0] e, got;
    x = 10'(sx); y = 10'(sy);
    in_display_area = ide; frame_start = fs;
    vis = m_synced && ide;
    a = m_base + 15'((sy / 8) * 80 + sx / 8);
    h = m_cen && (a == m_cur);
    ed = (sx % 8 == 0) || (sx % 8 == 7) || (sy % 8 == 0) || (sy % 8 == 7);
    e = vis ? {1'b1, colour(h, ed, tape[a])} : 13'd0;
    if (vis) m_addr = a;
    if (fs) begin
      m_synced = 1'b1; m_base = view_base;
      m_cur = cursor_addr; m_cen = cursor_en;
    end
    @(posedge clk); #1;
    n_vec++;
    if (vga_data_addr !== m_addr) begin
      n_err++;
      $display("FAIL addr at (%0d,%0d): got %h expected %h",
               sx, sy, vga_data_addr, m_addr);
    end
    q.push_back(e);
    if (q.size() >= 3) begin
      e = q.pop_front();
      got = {pix_valid, pix_rgb};
      n_vec++;
      if (got !== e) begin
        n_err++;
        $display("FAIL pixel {valid,rgb}: got %h expected %h", got, e);
      end
    end
  endtask

  task automatic do_reset(input int sx, input int sy, input bit ide);
    resetn = 1'b0;
    x = 10'(sx); y = 10'(sy);
    in_display_area = ide; frame_start = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    m_synced = 1'b0; m_cen = 1'b0;
    m_base = '0; m_cur = '0; m_addr = '0;
    q.delete();
    q.push_back(13'd0);
    q.push_back(13'd0);
    n_vec++;
    if ({vga_data_addr, pix_valid, pix_rgb} !== 28'd0) begin
      n_err++;
      $display("FAIL reset outputs: got addr=%h valid=%b rgb=%h required 0",
               vga_data_addr, pix_valid, pix_rgb);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic run_rows(input int y0, input int y1, input int npix,
                          input int hot_col);
    int sx;
    for (int r = y0; r <= y1; r++) begin
      for (int k = 0; k < npix; k++) begin
        if ($urandom_range(3) == 0)
          step(int'($urandom_range(639)), r, 0, 0);
        if (hot_col >= 0 && $urandom_range(2) == 0)
          sx = hot_col * 8 + int'($urandom_range(7));
        else
          sx = int'($urandom_range(638));
        step(sx, r, 1, 0);
      end
      step(639, r, 1, 0);
    end
  endtask

  task automatic test_reset();
    fill_tape();
    view_base = '0; cursor_addr = '0; cursor_en = 1'b0;
    do_reset(0, 0, 0);
    // Unsynced raster: address frozen, pixels blank.
    step(100, 10, 1, 0);
    step(8, 0, 1, 0);
    idle(2);
  endtask

  task automatic test_first_pixel();
    tape[0] = 8'h00; tape[1] = 8'hFF;
    view_base = '0; cursor_en = 1'b0;
    step(0, 0, 0, 1);
    step(8, 0, 1, 0);
    n_vec++;
    if (vga_data_addr !== 15'd1) begin
      n_err++;
      $display("FAIL first_addr: got %h required 0001", vga_data_addr);
    end
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    n_vec++;
    if ({pix_valid, pix_rgb} !== 13'h1FFF) begin
      n_err++;
      $display("FAIL first_pix: got %b/%h required 1/FFF",
               pix_valid, pix_rgb);
    end
    step(0, 0, 0, 0);
    n_vec++;
    if ({pix_valid, pix_rgb} !== 13'h1000) begin
      n_err++;
      $display("FAIL zero_cell_pix: got %b/%h required 1/000",
               pix_valid, pix_rgb);
    end
    idle(2);
  endtask

  task automatic test_row_scan();
    view_base = '0;
    step(0, 0, 0, 1);
    run_rows(0, 7, 3, -1);
    step(639, 8, 1, 0);
    n_vec++;
    if (vga_data_addr !== 15'd159) begin
      n_err++;
      $display("FAIL row8_end: got %0d required 159", vga_data_addr);
    end
    run_rows(9, 15, 2, -1);
    step(0, 16, 1, 0);
    n_vec++;
    if (vga_data_addr !== 15'd160) begin
      n_err++;
      $display("FAIL row16_start: got %0d required 160", vga_data_addr);
    end
    idle(3);
  endtask

  task automatic test_wrap();
    view_base = 15'h7FF0;
    step(0, 0, 0, 1);
    step(128, 0, 1, 0);
    n_vec++;
    if (vga_data_addr !== 15'h0000) begin
      n_err++;
      $display("FAIL wrap: got %h required 0000", vga_data_addr);
    end
    run_rows(0, 9, 3, -1);
    idle(3);
  endtask

  task automatic test_midframe_base();
    view_base = '0;
    step(0, 0, 0, 1);
    run_rows(0, 3, 2, -1);
    view_base = 15'd100;
    step(16, 4, 1, 0);
    n_vec++;
    if (vga_data_addr !== 15'd2) begin
      n_err++;
      $display("FAIL midframe_hold: got %0d required 2", vga_data_addr);
    end
    run_rows(4, 9, 2, -1);
    step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    n_vec++;
    if (vga_data_addr !== 15'd100) begin
      n_err++;
      $display("FAIL new_frame_base: got %0d required 100", vga_data_addr);
    end
    idle(3);
  endtask

  task automatic test_cursor();
    tape[5] = 8'h24;
    view_base = '0; cursor_addr = 15'd5; cursor_en = 1'b1;
    step(0, 0, 0, 1);
    step(40, 0, 1, 0);
    step(42, 3, 1, 0);
    step(0, 0, 0, 0);
    n_vec++;
    if ({pix_valid, pix_rgb} !== 13'h1F00) begin
      n_err++;
      $display("FAIL cursor_edge: got %b/%h required 1/F00",
               pix_valid, pix_rgb);
    end
    step(0, 0, 0, 0);
    run_rows(0, 15, 3, 5);
    idle(3);
    cursor_en = 1'b0;
  endtask

  task automatic test_reset_midframe();
    view_base = 15'($urandom);
    step(0, 0, 0, 1);
    run_rows(0, 199, 1, -1);
    step(100, 200, 1, 0);
    do_reset(300, 200, 1);
    run_rows(200, 215, 2, -1);
    view_base = 15'($urandom);
    step(0, 0, 0, 1);
    run_rows(0, 15, 3, -1);
    idle(3);
  endtask

  task automatic test_random_frames();
    int col;
    for (int f = 0; f < 6; f++) begin
      fill_tape();
      col = int'($urandom_range(79));
      view_base = 15'($urandom);
      cursor_addr = view_base + 15'(int'($urandom_range(3)) * 80 + col);
      cursor_en = 1'($urandom_range(1));
      step(0, 0, 0, 1);
      run_rows(0, 10, 3, col);
      view_base = 15'($urandom);
      cursor_addr = 15'($urandom);
      cursor_en = ~cursor_en;
      run_rows(11, 31, 3, col);
      idle(3);
    end
  endtask

  task automatic test_back_to_back();
    view_base = 15'($urandom);
    cursor_en = 1'b0;
    step(0, 0, 0, 1);
    for (int i = 0; i < 80; i++) step(i * 8 + int'($urandom_range(7)), 0, 1, 0);
    step(639, 0, 1, 0);
    idle(3);
  endtask

  initial begin
    resetn = 1'b0;
    x = '0; y = '0;
    in_display_area = 1'b0; frame_start = 1'b0;
    view_base = '0; cursor_addr = '0; cursor_en = 1'b0;
    test_reset();
    test_first_pixel();
    test_row_scan();
    test_wrap();
    test_midframe_base();
    test_cursor();
    test_reset_midframe();
    test_random_frames();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
